// File: rtl/conv4x4_engine.sv
// conv4x4_engine
//   Loads a 4x4 signed 8-bit filter and slides it, stride 1, over a
//   PIC_DIM x PIC_DIM unsigned 8-bit picture. Each of the OUT_DIM x OUT_DIM
//   results is shifted right by SHIFT (arithmetic), saturated to a byte,
//   packed four per word (lane 0 = [31:24]) and written to word memory
//   starting at OUT_BASE.
//
//   Build option: define CONV_RELU_EN to saturate results to [0,255];
//   otherwise results saturate to the signed byte range [-128,127].
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle request, accepted only when idle
//   busy, done            run in progress / one-cycle end-of-run pulse
//   M                     filter word address to the filter store
//   filter_out1..4        filter rows 0..3 (valid the cycle after M)
//   pix_row, pix_col      strip request: row and first column
//   pix_word              4-pixel strip, [31:24] = column pix_col
//   adr, in, we           word memory write port
module conv4x4_engine #(
  parameter int PIC_DIM  = 13,
  parameter int OUT_BASE = 256,
  parameter int SHIFT    = 4,
  parameter int FILT_M   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] M,
  input  logic [31:0] filter_out1,
  input  logic [31:0] filter_out2,
  input  logic [31:0] filter_out3,
  input  logic [31:0] filter_out4,
  output logic [3:0]  pix_row,
  output logic [3:0]  pix_col,
  input  logic [31:0] pix_word,
  output logic [31:0] adr,
  output logic [31:0] in,
  output logic        we
);
  localparam int OUT_DIM  = PIC_DIM - 3;
  localparam int LAST_IDX = OUT_DIM * OUT_DIM - 1;
  localparam int IDX_W    = $clog2(OUT_DIM * OUT_DIM);

  typedef enum logic [3:0] {
    S_IDLE, S_FLOAD, S_FCAP, S_R0, S_R1, S_R2, S_R3, S_QNT, S_WR, S_DONE
  } state_t;

  state_t              state;
  logic [31:0]         filt_reg [4];
  logic signed [20:0]  acc_reg;
  logic [31:0]         pack_reg;
  logic [3:0]          ox_reg, oy_reg;
  logic [IDX_W-1:0]    idx_reg;

  // Filter row used by the current accumulate state
  logic [31:0] frow;
  always_comb begin
    case (state)
      S_R1:    frow = filt_reg[1];
      S_R2:    frow = filt_reg[2];
      S_R3:    frow = filt_reg[3];
      default: frow = filt_reg[0];
    endcase
  end

  // Four column products: pixel zero-extended to 9 bits times signed tap
  logic signed [16:0] prod [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_prod
      assign prod[gi] = $signed({1'b0, pix_word[31-8*gi -: 8]}) * $signed(frow[31-8*gi -: 8]);
    end
  endgenerate

  logic signed [20:0] row_sum;
  assign row_sum = 21'(prod[0]) + 21'(prod[1]) + 21'(prod[2]) + 21'(prod[3]);

  // Requantise and saturate
  logic signed [20:0] q;
  logic [7:0]         qbyte;
  assign q = acc_reg >>> SHIFT;
  always_comb begin
`ifdef CONV_RELU_EN
    if (q < 21'sd0)        qbyte = 8'h00;
    else if (q > 21'sd255) qbyte = 8'hFF;
    else                   qbyte = q[7:0];
`else
    if (q < -21'sd128)     qbyte = 8'h80;
    else if (q > 21'sd127) qbyte = 8'h7F;
    else                   qbyte = q[7:0];
`endif
  end

  // Pack register with the new byte dropped into lane idx mod 4
  logic [31:0] pack_ins;
  always_comb begin
    pack_ins = pack_reg;
    case (idx_reg[1:0])
      2'd0:    pack_ins[31:24] = qbyte;
      2'd1:    pack_ins[23:16] = qbyte;
      2'd2:    pack_ins[15:8]  = qbyte;
      default: pack_ins[7:0]   = qbyte;
    endcase
  end

  // Next output position in raster order
  logic [3:0] ox_adv, oy_adv;
  logic       is_last;
  always_comb begin
    if (ox_reg == 4'(OUT_DIM - 1)) begin
      ox_adv = 4'd0;
      oy_adv = oy_reg + 4'd1;
    end else begin
      ox_adv = ox_reg + 4'd1;
      oy_adv = oy_reg;
    end
  end
  assign is_last = (idx_reg == IDX_W'(LAST_IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      we       <= 1'b0;
      adr      <= 32'd0;
      in       <= 32'd0;
      M        <= 32'd0;
      pix_row  <= 4'd0;
      pix_col  <= 4'd0;
      acc_reg  <= '0;
      pack_reg <= 32'd0;
      ox_reg   <= 4'd0;
      oy_reg   <= 4'd0;
      idx_reg  <= '0;
      for (int i = 0; i < 4; i++) filt_reg[i] <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FLOAD;
            busy     <= 1'b1;
            M        <= 32'(FILT_M);
            pack_reg <= 32'd0;
          end
        end
        S_FLOAD: state <= S_FCAP;
        S_FCAP: begin
          filt_reg[0] <= filter_out1;
          filt_reg[1] <= filter_out2;
          filt_reg[2] <= filter_out3;
          filt_reg[3] <= filter_out4;
          ox_reg  <= 4'd0;
          oy_reg  <= 4'd0;
          idx_reg <= '0;
          pix_row <= 4'd0;
          pix_col <= 4'd0;
          state   <= S_R0;
        end
        S_R0: begin
          acc_reg <= row_sum;
          pix_row <= oy_reg + 4'd1;
          state   <= S_R1;
        end
        S_R1: begin
          acc_reg <= acc_reg + row_sum;
          pix_row <= oy_reg + 4'd2;
          state   <= S_R2;
        end
        S_R2: begin
          acc_reg <= acc_reg + row_sum;
          pix_row <= oy_reg + 4'd3;
          state   <= S_R3;
        end
        S_R3: begin
          acc_reg <= acc_reg + row_sum;
          state   <= S_QNT;
        end
        S_QNT: begin
          if (idx_reg[1:0] == 2'd3 || is_last) begin
            // Word complete: present it during WR and start a fresh word
            we       <= 1'b1;
            adr      <= 32'(OUT_BASE) + 32'(idx_reg >> 2);
            in       <= pack_ins;
            pack_reg <= 32'd0;
            state    <= S_WR;
          end else begin
            pack_reg <= pack_ins;
            ox_reg   <= ox_adv;
            oy_reg   <= oy_adv;
            idx_reg  <= idx_reg + 1'b1;
            pix_row  <= oy_adv;
            pix_col  <= ox_adv;
            state    <= S_R0;
          end
        end
        S_WR: begin
          we <= 1'b0;
          if (is_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            ox_reg  <= ox_adv;
            oy_reg  <= oy_adv;
            idx_reg <= idx_reg + 1'b1;
            pix_row <= oy_adv;
            pix_col <= ox_adv;
            state   <= S_R0;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv4x4_engine.sv
// Testbench for conv4x4_engine: picture and filter store models, a
// convolution reference model computed directly from the sliding-window
// definition, and directed/random runs checked with immediate assertions.
module tb_conv4x4_engine;
  localparam int PIC_DIM  = 13;
  localparam int OUT_DIM  = PIC_DIM - 3;
  localparam int OUT_BASE = 256;
  localparam int SHIFT    = 4;
  localparam int FILT_M   = 0;
  localparam int N_WORDS  = (OUT_DIM * OUT_DIM + 3) / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, we;
  logic [31:0] M, adr, in;
  logic [31:0] filter_out1, filter_out2, filter_out3, filter_out4;
  logic [3:0]  pix_row, pix_col;
  logic [31:0] pix_word;

  always #5 clk = ~clk;

  conv4x4_engine #(.PIC_DIM(PIC_DIM), .OUT_BASE(OUT_BASE), .SHIFT(SHIFT), .FILT_M(FILT_M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .M(M),
    .filter_out1(filter_out1), .filter_out2(filter_out2),
    .filter_out3(filter_out3), .filter_out4(filter_out4),
    .pix_row(pix_row), .pix_col(pix_col), .pix_word(pix_word),
    .adr(adr), .in(in), .we(we)
  );

  // Picture and filter contents
  logic [7:0]  pic [PIC_DIM][PIC_DIM];
  logic [7:0]  fb  [4][4];
  logic [31:0] filt_w [4];

  // Picture strip source (combinational)
  int pc;
  always_comb begin
    pix_word = 32'd0;
    pc = 0;
    for (int k = 0; k < 4; k++) begin
      pc = int'(pix_col) + k;
      if (int'(pix_row) < PIC_DIM && pc < PIC_DIM)
        pix_word[31-8*k -: 8] = pic[pix_row][pc];
    end
  end

  // Filter store: registered read, only FILT_M holds the filter
  always @(posedge clk) begin
    if (M == 32'(FILT_M)) begin
      filter_out1 <= filt_w[0];
      filter_out2 <= filt_w[1];
      filter_out3 <= filt_w[2];
      filter_out4 <= filt_w[3];
    end else begin
      filter_out1 <= 32'hxxxxxxxx;
      filter_out2 <= 32'hxxxxxxxx;
      filter_out3 <= 32'hxxxxxxxx;
      filter_out4 <= 32'hxxxxxxxx;
    end
  end

  // Write and done monitor
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  int          n_done = 0;
  always @(negedge clk) begin
    if (we) begin
      wr_adr_q.push_back(adr);
      wr_dat_q.push_back(in);
      $display("write adr=%0d data=%08h", adr, in);
    end
    if (done) n_done++;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: straight from the convolution definition
  logic [31:0] exp_w [N_WORDS];

  function automatic logic [7:0] sat_ref(input int acc);
    int d, q;
    d = 1 << SHIFT;
    q = (acc >= 0) ? acc / d : -((-acc + d - 1) / d);  // floor division
`ifdef CONV_RELU_EN
    if (q < 0)   return 8'h00;
    if (q > 255) return 8'hFF;
`else
    if (q < -128) return 8'h80;
    if (q > 127)  return 8'h7F;
`endif
    return 8'(q);
  endfunction

  task automatic build_model();
    int acc, idx;
    for (int w = 0; w < N_WORDS; w++) exp_w[w] = 32'd0;
    for (int i = 0; i < 4; i++) filt_w[i] = {fb[i][0], fb[i][1], fb[i][2], fb[i][3]};
    for (int oy = 0; oy < OUT_DIM; oy++)
      for (int ox = 0; ox < OUT_DIM; ox++) begin
        acc = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            acc += int'(pic[oy+r][ox+c]) * int'($signed(fb[r][c]));
        idx = oy * OUT_DIM + ox;
        exp_w[idx/4] = exp_w[idx/4] | (32'(sat_ref(acc)) << (8 * (3 - idx % 4)));
      end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < PIC_DIM; r++)
      for (int c = 0; c < PIC_DIM; c++)
        case (mode)
          0: pic[r][c] = 8'($urandom);
          1: pic[r][c] = 8'h0A;
          2: pic[r][c] = 8'hFF;
          default: pic[r][c] = 8'(c);
        endcase
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        case (mode)
          0: fb[r][c] = 8'($urandom);
          1: fb[r][c] = 8'hFF;
          2: fb[r][c] = 8'h7F;
          default: fb[r][c] = (r == 0 && c == 0) ? 8'h10 : 8'h00;
        endcase
    build_model();
  endtask

  // One complete run with timing, write order and data checks
  task automatic run_check(input string tag, input bit hold_start);
    int cyc, bc, d0;
    wr_adr_q.delete();
    wr_dat_q.delete();
    d0 = n_done;
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold_start) start = 1'b0;
    cyc = 1;
    bc  = 0;
    forever begin
      if (busy) bc++;
      if (done || cyc >= 2000) break;
      @(negedge clk);
      cyc++;
      if (hold_start && cyc == 527) start = 1'b0;
    end
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    chk({tag, " done_cycle"}, 32'(cyc), 32'd528);
    chk({tag, " busy_cycles"}, 32'(bc), 32'd527);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    if (hold_start) begin
      start = 1'b1;              // pulse during DONE: must be ignored
      @(negedge clk); start = 1'b0;
      repeat (40) @(negedge clk);
      chk({tag, " busy_after"}, 32'(busy), 32'd0);
    end else begin
      repeat (3) @(negedge clk);
    end
    chk({tag, " done_pulses"}, 32'(n_done - d0), 32'd1);
    chk({tag, " write_count"}, 32'(wr_adr_q.size()), 32'(N_WORDS));
    for (int w = 0; w < N_WORDS; w++) begin
      chk($sformatf("%s adr[%0d]", tag, w),
          (w < wr_adr_q.size()) ? wr_adr_q[w] : 32'hxxxxxxxx, 32'(OUT_BASE + w));
      chk($sformatf("%s data[%0d]", tag, w),
          (w < wr_dat_q.size()) ? wr_dat_q[w] : 32'hxxxxxxxx, exp_w[w]);
    end
    $display("run %s: %0d writes, done at cycle %0d", tag, wr_adr_q.size(), cyc);
  endtask

  initial begin
    int w0;
    rst_n = 1'b0;
    start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst we", 32'(we), 32'd0);
    chk("rst adr", adr, 32'd0);
    chk("rst in", in, 32'd0);
    chk("rst M", M, 32'd0);
    chk("rst pix_row", 32'(pix_row), 32'd0);
    chk("rst pix_col", 32'(pix_col), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill(0); run_check("random_a", 1'b0);
    fill(1); run_check("neg_acc", 1'b0);
    fill(2); run_check("pos_sat", 1'b0);
    fill(3); run_check("ramp", 1'b0);
    chk("ramp word0", exp_w[0], 32'h00010203);
    chk("ramp word2", exp_w[2], 32'h08090001);
    fill(0); run_check("held_start", 1'b1);

    // Abort mid-run with reset; nothing may be written afterwards
    fill(0);
    wr_adr_q.delete();
    wr_dat_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (199) @(negedge clk);
    rst_n = 1'b0;
    w0 = wr_adr_q.size();
    @(negedge clk);
    chk("abort we", 32'(we), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort adr", adr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort no_writes", 32'(wr_adr_q.size()), 32'(w0));
    chk("abort idle", 32'(busy), 32'd0);
    fill(0); run_check("after_abort", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/conv4x4_engine.md
Name: conv4x4_engine

Overview:
- Downstream consumer of the per-PE output/filter memory stage.
- Loads one 4x4 signed 8-bit filter (four 32-bit row words).
- Slides the filter over a 13x13 unsigned 8-bit picture with stride 1, producing a 10x10 result map.
- Each result is requantised to a byte; four bytes are packed per word and written to the shared word memory through its adr/in/we write port.

Parameters:
- PIC_DIM, 13, picture edge length; output edge OUT_DIM = PIC_DIM-3.
- OUT_BASE, 256, first memory word address for results.
- SHIFT, 4, arithmetic right shift applied to the accumulator before saturation.
- FILT_M, 0, filter word address driven on M during the filter load.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at run end.
- M  out  32  filter word address to the filter store.
- filter_out1..filter_out4  in  32 each  filter rows 0..3, registered by the store (valid the cycle after M); byte [31:24] is column 0.
- pix_row  out  4  picture row of the requested 4-pixel strip.
- pix_col  out  4  first picture column of the strip.
- pix_word  in  32  combinational strip: [31:24]=px[row][col], [23:16]=col+1, [15:8]=col+2, [7:0]=col+3.
- adr  out  32  memory write address.
- in  out  32  memory write data.
- we  out  1  memory write enable, one cycle per word.

Behaviour:
- Reset values: busy=0, done=0, we=0, adr=0, in=0, M=0, pix_row=0, pix_col=0.
- Reset also clears the accumulator, pack register, counters and filter registers, and forces IDLE.
- Asserting rst_n low mid-run aborts immediately. No partial word is written after reset.
- IDLE: start=1 moves to FLOAD; start is ignored in every other state.
- FLOAD, 1 cycle: drive M=FILT_M.
- FCAP, 1 cycle: register the four filter words. Output row oy=0, column ox=0.
- R0..R3, 1 cycle each, for row r:
  - pix_row=oy+r, pix_col=ox.
  - Four signed products (unsigned pixel zero-extended to 9 bits × signed filter byte, 17-bit results).
  - acc += sum of the four products; R0 loads instead of adding.
  - acc is 21-bit signed; it never overflows.
- QNT, 1 cycle:
  - q = acc >>> SHIFT, arithmetic.
  - Saturate q to a byte (see Optional Feature).
  - Insert the byte into pack lane (idx mod 4), where idx = oy*OUT_DIM+ox. Lane 0 is [31:24].
  - If lane==3 or idx is the last output, go to WR. Otherwise advance ox (wrapping to 0 and incrementing oy) and go to R0.
- WR, 1 cycle:
  - we=1, adr=OUT_BASE+(idx>>2), in=pack.
  - Unused lanes of a final partial word are 0.
  - Clear pack. If idx was the last output, go to DONE; otherwise advance ox/oy and go to R0.
- DONE, 1 cycle: done=1, busy=0 in the same cycle, then IDLE.
- busy stays 1 throughout FLOAD..WR.
- Latency for PIC_DIM=13: 100 outputs × 5 cycles + 25 WR + FLOAD + FCAP = 527 cycles. done is high on the 528th cycle after the start edge.
- A start arriving in the DONE cycle is ignored.
- Filter registers persist after DONE and are reloaded on every run.
- adr, in and pix_* hold their last values when not in use. Only we qualifies writes.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: saturate q to the unsigned range [0,255]; negatives become 0x00.
- Undefined: saturate q to the signed range [-128,127], two's complement byte.

Test Plan:
- All pixels 0x01, filter all 0x01, SHIFT=0, start pulse -> 25 writes of 0x10101010 to adr 256..280 in increasing order. done on cycle 528, busy high for 527 cycles.
- Pixels all 0x0A, filter all 0xFF (-1), SHIFT=0 -> acc = -160.
  - With CONV_RELU_EN: every word 0x00000000.
  - Without: every word 0x80808080.
- Pixels all 0xFF, filter all 0x7F, SHIFT=4 -> acc = 518160, q = 32385.
  - With CONV_RELU_EN: words 0xFFFFFFFF.
  - Without: words 0x7F7F7F7F.
- Ramp picture px[r][c]=c, filter with only row0/col0 = 0x01, SHIFT=0 -> output bytes equal ox. First word 0x00010203, second word 0x04050607, word at adr 258 = 0x08090001 (row wrap).
- rst_n pulled low at cycle 200 of a run, then start reapplied -> no we during or after reset until the new run. The new run produces the full 25 correct writes.
- start held high for the whole run and pulsed again during DONE -> exactly one run. done is asserted once and busy returns to 0.
